// File: rtl/gc_conf_pkg.sv
// Shared encodings for the conf_ack tracker: FSM states and configurable component IDs.
package gc_conf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int CID_NONE   = 0;
    localparam int CID_CLKGEN = 1;
    localparam int CID_INIT   = 2;
    localparam int CID_STRIDE = 3;
    localparam int CID_MINMAX = 4;
    localparam int CID_CSG    = 5;
    localparam int CID_REINIT = 6;

endpackage

// File: rtl/conf_ack_timeout_cnt.sv
// WAIT-cycle counter for the conf_ack tracker; tc flags the last cycle before timeout.
// Only instantiated when CONF_ACK_TIMEOUT_EN is defined.
module conf_ack_timeout_cnt
    import gc_conf_pkg::*;
#(
    parameter int CNT_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_WIDTH-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tc = (cnt_reg == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/conf_ack_tracker.sv
// Tracks one configuration load at a time: latches the target ID, waits for its conf_ack,
// pulses ack_out and keeps a sticky done mask. Optional timeout via CONF_ACK_TIMEOUT_EN.
module conf_ack_tracker
    import gc_conf_pkg::*;
#(
    parameter int NUM_COMP       = 6,
    parameter int SELECT_WIDTH   = 3,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic [SELECT_WIDTH-1:0] sel,
    input  logic [NUM_COMP-1:0]     ack_in,
    input  logic                    clear_mask,
    output logic                    busy,
    output logic                    ack_out,
    output logic                    timeout_err,
    output logic [NUM_COMP-1:0]     ack_done_mask,
    output logic [SELECT_WIDTH-1:0] cur_sel
);

    state_t                  state_reg, state_next;
    logic [SELECT_WIDTH-1:0] sel_reg, sel_next;
    logic [NUM_COMP-1:0]     mask_reg, mask_next;
    logic [NUM_COMP-1:0]     sel_hit;
    logic                    sel_ack;
    logic                    req_legal;
    logic                    wait_timeout;

    // Elaborates only for an inconsistent parameter set.
    if ((2 ** SELECT_WIDTH) <= NUM_COMP || TIMEOUT_CYCLES < 1 ||
        TIMEOUT_CYCLES >= (2 ** CNT_WIDTH)) begin : g_illegal_config
        localparam bit CONFIG_ERROR = 1'b1;
    end

    // One-hot decode of the latched ID; bit k-1 belongs to component k.
    for (genvar gi = 0; gi < NUM_COMP; gi++) begin : g_sel_hit
        assign sel_hit[gi] = (sel_reg == SELECT_WIDTH'(gi + 1));
    end

    assign sel_ack   = |(sel_hit & ack_in);
    assign req_legal = req && (sel != '0) && (sel <= SELECT_WIDTH'(NUM_COMP));

`ifdef CONF_ACK_TIMEOUT_EN
    logic cnt_tc;
    logic terr_reg, terr_next;

    conf_ack_timeout_cnt #(
        .CNT_WIDTH      (CNT_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_reg != WAIT),
        .en    ((state_reg == WAIT) && !sel_ack),
        .tc    (cnt_tc)
    );

    assign wait_timeout = cnt_tc;
    // A timeout raised in the same cycle as clear_mask survives, matching the mask rule.
    assign terr_next    = (clear_mask ? 1'b0 : terr_reg) |
                          ((state_reg == WAIT) && !sel_ack && cnt_tc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            terr_reg <= 1'b0;
        end else begin
            terr_reg <= terr_next;
        end
    end

    assign timeout_err = terr_reg;
`else
    assign wait_timeout = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        mask_next  = clear_mask ? '0 : mask_reg;
        case (state_reg)
            IDLE: begin
                if (req_legal) begin
                    sel_next   = sel;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (sel_ack) begin
                    mask_next  = mask_next | sel_hit;
                    sel_next   = '0;
                    state_next = DONE;
                end else if (wait_timeout) begin
                    sel_next   = '0;
                    state_next = IDLE;
                end
            end
            DONE: begin
                sel_next   = '0;
                state_next = IDLE;
            end
            default: begin
                sel_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sel_reg   <= '0;
            mask_reg  <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            mask_reg  <= mask_next;
        end
    end

    assign busy          = (state_reg == WAIT);
    assign ack_out       = (state_reg == DONE);
    assign ack_done_mask = mask_reg;
    assign cur_sel       = sel_reg;

endmodule

// File: tb/tb_conf_ack_tracker.sv
// Self-checking bench for conf_ack_tracker: directed vector table plus hand-written
// sequences for reset abort and (when CONF_ACK_TIMEOUT_EN is defined) timeout.
module tb_conf_ack_tracker;
    import gc_conf_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic [2:0] sel;
    logic [5:0] ack_in;
    logic       clear_mask;
    logic       busy;
    logic       ack_out;
    logic       timeout_err;
    logic [5:0] ack_done_mask;
    logic [2:0] cur_sel;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conf_ack_tracker #(
        .NUM_COMP       (6),
        .SELECT_WIDTH   (3),
        .TIMEOUT_CYCLES (4),
        .CNT_WIDTH      (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .sel           (sel),
        .ack_in        (ack_in),
        .clear_mask    (clear_mask),
        .busy          (busy),
        .ack_out       (ack_out),
        .timeout_err   (timeout_err),
        .ack_done_mask (ack_done_mask),
        .cur_sel       (cur_sel)
    );

    typedef struct {
        logic       req;
        logic [2:0] sel;
        logic [5:0] ack;
        logic       clr;
        logic       busy;
        logic       ack_out;
        logic [2:0] cur_sel;
        logic [5:0] mask;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [2:0] s, logic [5:0] a, logic c,
                                logic b, logic ao, logic [2:0] cs, logic [5:0] m);
        vec_t v;
        v.req = r; v.sel = s; v.ack = a; v.clr = c;
        v.busy = b; v.ack_out = ao; v.cur_sel = cs; v.mask = m;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic [2:0] s, logic [5:0] a, logic c);
        req = r; sel = s; ack_in = a; clear_mask = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(string tag, logic b, logic ao, logic te, logic [2:0] cs, logic [5:0] m);
        chk({tag, ".busy"},    32'(busy),          32'(b));
        chk({tag, ".ack_out"}, 32'(ack_out),       32'(ao));
        chk({tag, ".timeout"}, 32'(timeout_err),   32'(te));
        chk({tag, ".cur_sel"}, 32'(cur_sel),       32'(cs));
        chk({tag, ".mask"},    32'(ack_done_mask), 32'(m));
    endtask

    initial begin
        // Basic handshake, sel=3 acked after 4 WAIT cycles
        vecs.push_back(mk(1, 3'd3, 6'b000000, 0,  1, 0, 3'd3, 6'b000000));
        vecs.push_back(mk(0, 3'd0, 6'b000000, 0,  1, 0, 3'd3, 6'b000000));
        vecs.push_back(mk(0, 3'd0, 6'b000000, 0,  1, 0, 3'd3, 6'b000000));
        vecs.push_back(mk(0, 3'd0, 6'b000000, 0,  1, 0, 3'd3, 6'b000000));
        vecs.push_back(mk(0, 3'd0, 6'b000100, 0,  0, 1, 3'd0, 6'b000100));
        vecs.push_back(mk(0, 3'd0, 6'b000000, 0,  0, 0, 3'd0, 6'b000100));
        // Wrong-component acks for sel=2 are ignored
        vecs.push_back(mk(1, 3'd2, 6'b000000, 0,  1, 0, 3'd2, 6'b000100));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(0, 3'd0, 6'b100001, 0,  1, 0, 3'd2, 6'b000100));
        vecs.push_back(mk(0, 3'd0, 6'b000010, 0,  0, 1, 3'd0, 6'b000110));
        vecs.push_back(mk(0, 3'd0, 6'b000000, 0,  0, 0, 3'd0, 6'b000110));
        // Illegal / idle selects
        vecs.push_back(mk(1, 3'd0, 6'b000000, 0,  0, 0, 3'd0, 6'b000110));
        vecs.push_back(mk(1, 3'd7, 6'b000000, 0,  0, 0, 3'd0, 6'b000110));
        // req while busy and while in DONE is ignored
        vecs.push_back(mk(1, 3'd1, 6'b000000, 0,  1, 0, 3'd1, 6'b000110));
        vecs.push_back(mk(1, 3'd5, 6'b010000, 0,  1, 0, 3'd1, 6'b000110));
        vecs.push_back(mk(1, 3'd5, 6'b000001, 0,  0, 1, 3'd0, 6'b000111));
        vecs.push_back(mk(1, 3'd5, 6'b000000, 0,  0, 0, 3'd0, 6'b000111));
        vecs.push_back(mk(0, 3'd0, 6'b000000, 0,  0, 0, 3'd0, 6'b000111));
        // clear_mask racing an ack for sel=4: the set bit survives
        vecs.push_back(mk(1, 3'd4, 6'b000000, 0,  1, 0, 3'd4, 6'b000111));
        vecs.push_back(mk(0, 3'd0, 6'b001000, 1,  0, 1, 3'd0, 6'b001000));
        vecs.push_back(mk(0, 3'd0, 6'b000000, 0,  0, 0, 3'd0, 6'b001000));
        vecs.push_back(mk(0, 3'd0, 6'b000000, 1,  0, 0, 3'd0, 6'b000000));
        // Ack already high on WAIT entry: minimum 2-cycle request-to-pulse
        vecs.push_back(mk(1, 3'd6, 6'b100000, 0,  1, 0, 3'd6, 6'b000000));
        vecs.push_back(mk(0, 3'd0, 6'b100000, 0,  0, 1, 3'd0, 6'b100000));
        vecs.push_back(mk(0, 3'd0, 6'b000000, 0,  0, 0, 3'd0, 6'b100000));

        rst_n = 1'b0;
        drive(0, 3'd0, 6'b0, 0);
        repeat (3) tick();
        chk_outs("reset", 0, 0, 0, 3'd0, 6'b0);
        rst_n = 1'b1;
        tick();
        chk_outs("post_reset", 0, 0, 0, 3'd0, 6'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].req, vecs[i].sel, vecs[i].ack, vecs[i].clr);
            tick();
            $display("row %0d req=%0b sel=%0d ack=%b clr=%0b -> busy=%0b ack_out=%0b cur_sel=%0d mask=%b",
                     i, vecs[i].req, vecs[i].sel, vecs[i].ack, vecs[i].clr,
                     busy, ack_out, cur_sel, ack_done_mask);
            chk_outs($sformatf("row%0d", i), vecs[i].busy, vecs[i].ack_out, 1'b0,
                     vecs[i].cur_sel, vecs[i].mask);
        end

        // Reset in the middle of WAIT aborts without a pulse
        drive(1, 3'd2, 6'b0, 0);
        tick();
        chk_outs("rst_pre", 1, 0, 0, 3'd2, 6'b100000);
        drive(0, 3'd0, 6'b000010, 0);
        #2 rst_n = 1'b0;
        #1;
        chk_outs("rst_async", 0, 0, 0, 3'd0, 6'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_outs("rst_after1", 0, 0, 0, 3'd0, 6'b0);
        drive(0, 3'd0, 6'b0, 0);
        tick();
        chk_outs("rst_after2", 0, 0, 0, 3'd0, 6'b0);
        $display("txn reset-abort busy=%0b ack_out=%0b mask=%b", busy, ack_out, ack_done_mask);

`ifdef CONF_ACK_TIMEOUT_EN
        // sel=6 never acks: 4 WAIT cycles then timeout
        drive(1, 3'd6, 6'b0, 0);
        tick();
        drive(0, 3'd0, 6'b0, 0);
        chk_outs("to_w0", 1, 0, 0, 3'd6, 6'b0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk_outs($sformatf("to_w%0d", i), 1, 0, 0, 3'd6, 6'b0);
        end
        tick();
        chk_outs("to_fire", 0, 0, 1, 3'd0, 6'b0);
        tick();
        chk_outs("to_sticky", 0, 0, 1, 3'd0, 6'b0);
        drive(0, 3'd0, 6'b0, 1);
        tick();
        drive(0, 3'd0, 6'b0, 0);
        chk_outs("to_clear", 0, 0, 0, 3'd0, 6'b0);
        $display("txn timeout sel=6 timeout_err cleared=%0b", timeout_err);
        // Ack in the terminal-count cycle wins
        drive(1, 3'd1, 6'b0, 0);
        tick();
        drive(0, 3'd0, 6'b0, 0);
        repeat (3) tick();
        chk_outs("tc_w3", 1, 0, 0, 3'd1, 6'b0);
        drive(0, 3'd0, 6'b000001, 0);
        tick();
        chk_outs("tc_ack", 0, 1, 0, 3'd0, 6'b000001);
        drive(0, 3'd0, 6'b0, 0);
        tick();
        $display("txn terminal-count ack mask=%b", ack_done_mask);
`else
        // Without the timeout feature WAIT lasts indefinitely
        drive(1, 3'd6, 6'b0, 0);
        tick();
        drive(0, 3'd0, 6'b0, 0);
        repeat (20) tick();
        chk_outs("nto_wait", 1, 0, 0, 3'd6, 6'b0);
        drive(0, 3'd0, 6'b100000, 0);
        tick();
        chk_outs("nto_ack", 0, 1, 0, 3'd0, 6'b100000);
        drive(0, 3'd0, 6'b0, 0);
        tick();
        $display("txn no-timeout long wait mask=%b", ack_done_mask);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
